uartb_rx_packer: RTL and testbench

- Receive-side stage directly downstream of the UARTB core's RX path.
- Drains received bytes from the core (rx_byte/rx_dv, rd pulse) and packs them into 32-bit little-endian words for the host bus.
- Burst mode: 4 bytes per word, first byte in [7:0], mirroring the 32-bit burst TX format.
- Normal mode: 1 byte per word.

---
 rtl/uartb_pkg.sv | 21 ++
 rtl/uartb_idle_timer.sv | 41 ++++
 rtl/uartb_rx_packer.sv | 150 +++++++++++++++
 tb/tb_uartb_rx_packer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uartb_pkg.sv
// uartb_pkg: shared types and helpers for the UARTB receive packer.
// FSM states, word geometry, mode encodings and the lane-mask helper.
package uartb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FLUSH
  } rxp_state_e;

  localparam int   BYTES_PER_WORD = 4;
  localparam logic MODE_NORMAL    = 1'b0;
  localparam logic MODE_BURST     = 1'b1;

  function automatic logic [3:0] lane_mask(
    input logic [1:0] idx
  );
    lane_mask = 4'((4'b0001 << idx) - 4'd1);
  endfunction

endpackage

// File: rtl/uartb_idle_timer.sv
// uartb_idle_timer: saturating idle counter with an expiry flag.
// Clears on clr, counts while en, holds at LIMIT and flags it.
module uartb_idle_timer
  import uartb_pkg::*;
#(
  parameter int LIMIT = 1024,
  parameter int W     = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         at_lim;

  // next count: clear wins, then count up until the limit
  always_comb begin
    cnt_d  = cnt_q;
    at_lim = (cnt_q == W'(LIMIT));
    if (clr) begin
      cnt_d = '0;
    end else if (en && !at_lim) begin
      cnt_d = cnt_q + W'(1);
    end
    expire = en && at_lim;
  end

  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uartb_rx_packer.sv
// uartb_rx_packer: drains UARTB RX bytes into 32-bit LE host words.
// UARTB_RXPACK_TIMEOUT_EN adds an idle flush of partial burst words.
module uartb_rx_packer
  import uartb_pkg::*;
#(
  parameter int IDLE_TO = 1024,
  parameter int TO_W    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mode,
  input  logic [7:0]  rx_byte,
  input  logic        rx_dv,
  output logic        rx_rd,
  output logic [31:0] word_data,
  output logic [3:0]  word_be,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [1:0]  byte_idx
);

  rxp_state_e  state_q, state_d;
  logic        mode_q, mode_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] acc_q, acc_d;
  logic        guard_q, guard_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  be_q, be_d;
  logic        valid_q, valid_d;

  logic eff_mode;
  logic last_lane;
  logic out_free;
  logic mode_drop;
  logic room;
  logic rd;
  logic timeout;

`ifdef UARTB_RXPACK_TIMEOUT_EN
  uartb_idle_timer #(
    .LIMIT (IDLE_TO),
    .W     (TO_W)
  ) u_idle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (rd || (state_q != ACCUM)),
    .en     (state_q == ACCUM),
    .expire (timeout)
  );
`else
  logic [TO_W-1:0] unused_idle_to;
  assign unused_idle_to = TO_W'(IDLE_TO);
  assign timeout        = 1'b0;
`endif

  // read qualification: one byte per guarded window, only with room
  always_comb begin
    eff_mode  = (idx_q == 2'd0) ? mode : mode_q;
    last_lane = (eff_mode == MODE_NORMAL)
             || (idx_q == 2'(BYTES_PER_WORD - 1));
    out_free  = !valid_q || word_ready;
    mode_drop = (state_q == ACCUM) && (mode != mode_q);
    room      = (state_q != FLUSH) && !mode_drop && !timeout
             && (!last_lane || out_free);
    rd        = rx_dv && !guard_q && room;
  end

  // packing FSM and output register next-state
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    data_d  = data_q;
    be_d    = be_q;
    guard_d = rd;
    valid_d = valid_q && !word_ready;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (rd) begin
          if (idx_q == 2'd0) begin
            mode_d = mode;
          end
          if ((eff_mode == MODE_BURST) && !last_lane) begin
            acc_d[{idx_q, 3'b000} +: 8] = rx_byte;
            idx_d   = 2'(idx_q + 2'd1);
            state_d = ACCUM;
          end else begin
            valid_d = 1'b1;
            if (eff_mode == MODE_BURST) begin
              data_d = {rx_byte, acc_q[23:0]};
              be_d   = 4'hF;
            end else begin
              data_d = {24'b0, rx_byte};
              be_d   = 4'h1;
            end
            acc_d   = '0;
            idx_d   = 2'd0;
            state_d = IDLE;
          end
        end else if (mode_drop || timeout) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (out_free) begin
          valid_d = 1'b1;
          data_d  = acc_q;
          be_d    = lane_mask(idx_q);
          acc_d   = '0;
          idx_d   = 2'd0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state registers; guard resets high so no read fires out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_NORMAL;
      idx_q   <= 2'd0;
      acc_q   <= '0;
      guard_q <= 1'b1;
      data_q  <= '0;
      be_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      guard_q <= guard_d;
      data_q  <= data_d;
      be_q    <= be_d;
      valid_q <= valid_d;
    end
  end

  assign rx_rd      = rd;
  assign word_data  = data_q;
  assign word_be    = be_q;
  assign word_valid = valid_q;
  assign byte_idx   = idx_q;

endmodule

// File: tb/tb_uartb_rx_packer.sv
// tb_uartb_rx_packer: scoreboard bench for the UARTB RX packer.
// Core model holds dv one cycle past rx_rd to exercise the read guard.
module tb_uartb_rx_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_dv = 1'b0;
  logic        word_ready = 1'b0;
  logic        rx_rd;
  logic [31:0] word_data;
  logic [3:0]  word_be;
  logic        word_valid;
  logic [1:0]  byte_idx;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  be;
  } word_t;

  word_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int b2b = 0;
  int words = 0;
  int last_rd_cyc = 0;
  int rise_lat = -1;
  logic prev_rd = 1'b0;
  logic prev_valid = 1'b0;

  uartb_rx_packer #(
    .IDLE_TO (16),
    .TO_W    (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .rx_byte    (rx_byte),
    .rx_dv      (rx_dv),
    .rx_rd      (rx_rd),
    .word_data  (word_data),
    .word_be    (word_be),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .byte_idx   (byte_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, act, want);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] be);
    word_t w;
    w.d  = d;
    w.be = be;
    sb.push_back(w);
  endtask

  // monitor: read pulses, valid latency, scoreboard pops on handshake
  always @(negedge clk) begin
    #2;
    if (rx_rd) begin
      rd_cnt++;
      last_rd_cyc = cyc;
      if (prev_rd) b2b++;
    end
    if (word_valid && !prev_valid) rise_lat = cyc - last_rd_cyc;
    if (word_valid && word_ready) begin
      words++;
      check("sb_pending", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        word_t e;
        e = sb.pop_front();
        check("word_data", word_data, e.d);
        check("word_be", 32'(word_be), 32'(e.be));
      end
    end
    prev_rd    = rx_rd;
    prev_valid = word_valid;
  end

  task automatic send(input logic [7:0] b);
    bit got;
    got = 1'b0;
    @(negedge clk);
    rx_byte = b;
    rx_dv   = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      #1;
      if (rx_rd) got = 1'b1;
      else @(negedge clk);
    end
    check("rd_seen", 32'(got), 1);
    @(negedge clk);
    @(posedge clk);
    #1;
    rx_dv = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #3;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd"}, 32'(rx_rd), 0);
    check({tag, "_data"}, word_data, 0);
    check({tag, "_be"}, 32'(word_be), 0);
    check({tag, "_valid"}, 32'(word_valid), 0);
    check({tag, "_idx"}, 32'(byte_idx), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int w0;
    rx_dv = 1'b1;
    rx_byte = 8'hEE;
    settle(3);
    check_zero("reset");
    rx_dv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // burst
    word_ready = 1'b1;
    mode = 1'b1;
    r0 = rd_cnt;
    push(32'h44434241, 4'hF);
    for (int i = 0; i < 4; i++) send(8'(8'h41 + i));
    settle(4);
    check("burst_rd_cnt", rd_cnt - r0, 4);
    check("burst_b2b", b2b, 0);
    check("burst_sb", sb.size(), 0);

    // normal
    mode = 1'b0;
    rise_lat = -1;
    push(32'h0000005A, 4'h1);
    send(8'h5A);
    settle(3);
    check("normal_lat", rise_lat, 1);
    check("normal_sb", sb.size(), 0);

    // backpressure
    mode = 1'b1;
    word_ready = 1'b0;
    push(32'h44434241, 4'hF);
    push(32'h48474645, 4'hF);
    for (int i = 0; i < 7; i++) send(8'(8'h41 + i));
    settle(1);
    check("bp_data0", word_data, 32'h44434241);
    check("bp_idx", 32'(byte_idx), 3);
    r0 = rd_cnt;
    fork
      send(8'h48);
      begin
        settle(12);
        check("bp_withheld", rd_cnt, r0);
        check("bp_hold_data", word_data, 32'h44434241);
        check("bp_hold_be", 32'(word_be), 32'hF);
        check("bp_hold_valid", 32'(word_valid), 1);
        @(negedge clk);
        word_ready = 1'b1;
        settle(1);
        check("bp_nobubble_v", 32'(word_valid), 1);
        check("bp_nobubble_d", word_data, 32'h48474645);
      end
    join
    settle(3);
    check("bp_sb", sb.size(), 0);

    // mode switch flush
    push(32'h00004241, 4'h3);
    push(32'h0000005A, 4'h1);
    send(8'h41);
    send(8'h42);
    @(negedge clk);
    mode = 1'b0;
    send(8'h5A);
    settle(4);
    check("msw_sb", sb.size(), 0);

    // idle timeout
    mode = 1'b1;
    w0 = words;
`ifdef UARTB_RXPACK_TIMEOUT_EN
    push(32'h00000041, 4'h1);
    send(8'h41);
    settle(40);
    check("to_sb", sb.size(), 0);
    check("to_idx", 32'(byte_idx), 0);
`else
    send(8'h41);
    settle(1000);
    check("noto_words", words, w0);
    check("noto_idx", 32'(byte_idx), 1);
    check("noto_valid", 32'(word_valid), 0);
    push(32'h00000041, 4'h1);
    @(negedge clk);
    mode = 1'b0;
    settle(5);
    check("noto_flush_sb", sb.size(), 0);
`endif

    // reset mid-burst
    mode = 1'b1;
    send(8'h41);
    send(8'h42);
    send(8'h43);
    settle(1);
    check("rst_pre_idx", 32'(byte_idx), 3);
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    sb.delete();
    settle(2);
    rst_n = 1'b1;
    push(32'h44434241, 4'hF);
    for (int i = 0; i < 4; i++) send(8'(8'h41 + i));
    settle(4);
    check("rst_post_sb", sb.size(), 0);

    check("final_b2b", b2b, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
